subleq_stream_mux: RTL and testbench
====================================

Name: subleq_stream_mux

Overview:
Parametrised, registered N-to-1 multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the 8-bit combinational 2:1 select used on the SUBLEQ datapath. It adds configurable width, configurable input count, an output register stage with back-pressure, and a round-robin arbitration mode. It sits between the operand/address sources (PC, memory read port, ALU result) and their shared consumers.

Parameters:
- WIDTH, 8, data width in bits.
- N_IN, 2, number of input channels (2..16).
- SEL_W, 1, width of sel and out_src; equals clog2(N_IN), minimum 1.
- MODE, 0, select mode: 0 = external select on sel; 1 = round-robin over valid inputs, sel ignored.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_data, input, N_IN*WIDTH, channel i is in_data[i*WIDTH +: WIDTH].
- in_valid, input, N_IN, per-channel valid.
- in_ready, output, N_IN, per-channel ready (combinational).
- sel, input, SEL_W, channel select (MODE 0 only).
- out_data, output, WIDTH, registered data.
- out_valid, output, 1, registered valid.
- out_ready, input, 1, downstream ready.
- out_src, output, SEL_W, index of the channel that supplied out_data (registered).

Behaviour:
- Reset: on a clk edge with rst_n=0, out_valid, out_data, out_src and the round-robin pointer ptr all go to 0. While rst_n=0, in_ready is forced to all 0.
- Reset mid-operation drops any held word; nothing is replayed.
- Load enable: load_en = !out_valid || out_ready. This gives single-register pass-through with full 1 word/cycle throughput while out_ready=1.
- Grant in MODE 0:
  - g = sel.
  - The grant is valid only if sel < N_IN. Out-of-range sel grants nothing.
  - With N_IN=2, sel=1 selects channel 1 and sel=0 selects channel 0. This matches the existing sel ? A : B convention, with A = channel 1.
- Grant in MODE 1:
  - g = the first i with in_valid[i]=1, scanning ptr, ptr+1, … wrapping modulo N_IN.
  - No grant if all in_valid are 0.
- in_ready[i] = rst_n && load_en && grant_valid && (g == i). At most one bit is set.
- Capture occurs when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= channel g data;
  - out_src <= g;
  - out_valid <= 1.
- In MODE 1, a capture also sets ptr <= (g+1) mod N_IN. The pointer holds when there is no capture.
- Drain: if out_valid && out_ready and there is no capture, out_valid <= 0 at the next edge. out_data and out_src hold their last values.
- Stall: if out_valid && !out_ready:
  - out_data, out_src and out_valid hold;
  - all in_ready = 0;
  - sel changes have no effect until the stall clears.
- Latency: exactly 1 clk from input handshake to out_valid.
- Simultaneous drain and capture in the same cycle: the new word replaces the old one, and out_valid stays 1.
- in_valid must not depend combinationally on in_ready. in_ready depends on in_valid only in MODE 1.
- No data is altered; the block never duplicates or drops an accepted word.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_src=0, in_ready=0; after release, the first capture occurs 1 cycle later.
2. MODE 0, N_IN=2, WIDTH=8: ch1=8'hA5, ch0=8'h3C, both valid, out_ready=1, sel=1 then 0 → out_data A5 (out_src=1), then 3C (out_src=0), on consecutive cycles.
3. Back-pressure: hold out_ready=0 for 5 cycles with a word held → out_data is stable and in_ready=0 throughout. Raise out_ready → a new word is captured on the same edge the old one drains, and out_valid stays 1.
4. MODE 1, N_IN=4, all valid, out_ready=1 → out_src sequence 0,1,2,3,0 on consecutive cycles.
5. MODE 1, N_IN=4, only channels 1 and 3 valid → out_src 1,3,1,3. Drop all valid → out_valid falls 1 cycle after the last accept.
6. MODE 0, N_IN=3, sel=3 (out of range) → in_ready=0, no capture, the held word drains, and out_valid=0. Assert rst_n=0 mid-stall → out_valid=0 at the next edge.

Source files
------------

// File: rtl/subleq_stream_mux.sv
// Registered N-to-1 stream multiplexer with valid/ready on every channel.
// External-select (MODE 0) or round-robin (MODE 1) arbitration feeding one output register.
module subleq_stream_mux #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int SEL_W = 1,
  parameter int MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  localparam int SEL_W_EXP = ($clog2(N_IN) < 1) ? 1 : $clog2(N_IN);

  if (N_IN < 2 || N_IN > 16) begin : g_bad_n_in
    $error("subleq_stream_mux: N_IN must be in 2..16");
  end
  if (SEL_W != SEL_W_EXP) begin : g_bad_sel_w
    $error("subleq_stream_mux: SEL_W must equal clog2(N_IN), minimum 1");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("subleq_stream_mux: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;

  logic             load_en;
  logic             grant_valid;
  logic [SEL_W-1:0] g;
  logic [WIDTH-1:0] g_data;
  logic             capture;

  // The output register can take a new word when empty or when it drains this cycle.
  assign load_en = !valid_q || out_ready;

  always_comb begin : grant_sel
    int idx;
    idx         = 0;
    g           = '0;
    grant_valid = 1'b0;
    if (MODE == 0) begin
      g           = sel;
      grant_valid = (int'(sel) < N_IN);
    end else begin
      // Scan downward so the lowest offset from ptr (the nearest valid channel) wins.
      for (int k = N_IN - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (in_valid[idx]) begin
          g           = SEL_W'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin : grant_data
    g_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (g == SEL_W'(i)) g_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin : ready_gen
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = rst_n && load_en && grant_valid && (g == SEL_W'(i));
    end
  end

  assign capture = |(in_ready & in_valid);

  always_comb begin : next_state
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (capture) begin
      data_d  = g_data;
      src_d   = g;
      valid_d = 1'b1;
      if (MODE != 0) begin
        ptr_d = (int'(g) == N_IN - 1) ? '0 : g + SEL_W'(1);
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_subleq_stream_mux.sv
// Directed bench for subleq_stream_mux: three instances cover MODE 0 / N_IN=2,
// MODE 1 / N_IN=4 and MODE 0 / N_IN=3 (out-of-range select).
module tb_subleq_stream_mux;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] d0_in_data;
  logic [1:0]  d0_in_valid, d0_in_ready;
  logic [0:0]  d0_sel, d0_out_src;
  logic [7:0]  d0_out_data;
  logic        d0_out_valid, d0_out_ready;

  logic [31:0] d1_in_data;
  logic [3:0]  d1_in_valid, d1_in_ready;
  logic [1:0]  d1_sel, d1_out_src;
  logic [7:0]  d1_out_data;
  logic        d1_out_valid, d1_out_ready;

  logic [23:0] d2_in_data;
  logic [2:0]  d2_in_valid, d2_in_ready;
  logic [1:0]  d2_sel, d2_out_src;
  logic [7:0]  d2_out_data;
  logic        d2_out_valid, d2_out_ready;

  subleq_stream_mux #(.WIDTH(8), .N_IN(2), .SEL_W(1), .MODE(0)) u_m0n2 (
    .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_src(d0_out_src));

  subleq_stream_mux #(.WIDTH(8), .N_IN(4), .SEL_W(2), .MODE(1)) u_m1n4 (
    .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_src(d1_out_src));

  subleq_stream_mux #(.WIDTH(8), .N_IN(3), .SEL_W(2), .MODE(0)) u_m0n3 (
    .clk(clk), .rst_n(rst_n), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_src(d2_out_src));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d0_in_data = {8'hA5, 8'h3C}; d0_in_valid = 2'b11; d0_sel = 1'b1; d0_out_ready = 1'b1;
    tick();
    tick();
    checks++; if (d0_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", d0_out_valid); end
    checks++; if (d0_out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", d0_out_data); end
    checks++; if (d0_out_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %b expected 0", d0_out_src); end
    checks++; if (d0_in_ready !== 2'b00) begin errors++; $display("FAIL reset_in_ready: got %b expected 00", d0_in_ready); end
    checks++; if (d1_out_valid !== 1'b0 || d2_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_others: got %b%b expected 00", d1_out_valid, d2_out_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (d0_in_ready !== 2'b10) begin errors++; $display("FAIL release_in_ready: got %b expected 10", d0_in_ready); end
    tick();
    checks++; if (d0_out_valid !== 1'b1 || d0_out_data !== 8'hA5 || d0_out_src !== 1'b1) begin errors++; $display("FAIL first_capture: got v=%b d=%h s=%b expected v=1 d=a5 s=1", d0_out_valid, d0_out_data, d0_out_src); end
  endtask

  task automatic test_mode0_select();
    d0_sel = 1'b1;
    tick();
    checks++; if (d0_out_data !== 8'hA5 || d0_out_src !== 1'b1) begin errors++; $display("FAIL sel1: got d=%h s=%b expected d=a5 s=1", d0_out_data, d0_out_src); end
    d0_sel = 1'b0;
    #1;
    checks++; if (d0_in_ready !== 2'b01) begin errors++; $display("FAIL sel0_ready: got %b expected 01", d0_in_ready); end
    tick();
    checks++; if (d0_out_data !== 8'h3C || d0_out_src !== 1'b0 || d0_out_valid !== 1'b1) begin errors++; $display("FAIL sel0: got v=%b d=%h s=%b expected v=1 d=3c s=0", d0_out_valid, d0_out_data, d0_out_src); end
  endtask

  task automatic test_back_pressure();
    d0_out_ready = 1'b0;
    d0_sel = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (d0_in_ready !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 00", i, d0_in_ready); end
      tick();
      checks++; if (d0_out_valid !== 1'b1 || d0_out_data !== 8'h3C || d0_out_src !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%b expected v=1 d=3c s=0", i, d0_out_valid, d0_out_data, d0_out_src); end
      d0_sel = ~d0_sel;
      #1;
    end
    d0_sel = 1'b1;
    d0_out_ready = 1'b1;
    #1;
    checks++; if (d0_in_ready !== 2'b10) begin errors++; $display("FAIL unstall_ready: got %b expected 10", d0_in_ready); end
    tick();
    checks++; if (d0_out_valid !== 1'b1 || d0_out_data !== 8'hA5 || d0_out_src !== 1'b1) begin errors++; $display("FAIL drain_and_capture: got v=%b d=%h s=%b expected v=1 d=a5 s=1", d0_out_valid, d0_out_data, d0_out_src); end
    d0_in_valid = 2'b00;
    tick();
    checks++; if (d0_out_valid !== 1'b0 || d0_out_data !== 8'hA5 || d0_out_src !== 1'b1) begin errors++; $display("FAIL drain: got v=%b d=%h s=%b expected v=0 d=a5 s=1", d0_out_valid, d0_out_data, d0_out_src); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    d0_in_valid = 2'b11;
    d0_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0_sel = i[0];
      exp_d = i[0] ? 8'hA5 : 8'h3C;
      tick();
      checks++; if (d0_out_valid !== 1'b1 || d0_out_data !== exp_d || d0_out_src !== i[0]) begin errors++; $display("FAIL b2b[%0d]: got v=%b d=%h s=%b expected v=1 d=%h s=%b", i, d0_out_valid, d0_out_data, d0_out_src, exp_d, i[0]); end
    end
    d0_in_valid = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    int e;
    d1_in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    d1_out_ready = 1'b1;
    d1_in_valid = 4'hF;
    #1;
    checks++; if (d1_in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready: got %b expected 0001", d1_in_ready); end
    for (int i = 0; i < 5; i++) begin
      e = i % 4;
      tick();
      checks++; if (d1_out_valid !== 1'b1 || d1_out_src !== 2'(e) || d1_out_data !== 8'(8'h10 + e)) begin errors++; $display("FAIL rr_all[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h", i, d1_out_valid, d1_out_src, d1_out_data, e, 8'(8'h10 + e)); end
    end
  endtask

  task automatic test_rr_sparse();
    int seq [4] = '{1, 3, 1, 3};
    d1_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (d1_out_valid !== 1'b1 || d1_out_src !== 2'(seq[i]) || d1_out_data !== 8'(8'h10 + seq[i])) begin errors++; $display("FAIL rr_sparse[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d", i, d1_out_valid, d1_out_src, d1_out_data, seq[i]); end
    end
    d1_in_valid = 4'b0000;
    #1;
    checks++; if (d1_in_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_ready: got %b expected 0000", d1_in_ready); end
    tick();
    checks++; if (d1_out_valid !== 1'b0 || d1_out_src !== 2'd3 || d1_out_data !== 8'h13) begin errors++; $display("FAIL rr_drain: got v=%b s=%0d d=%h expected v=0 s=3 d=13", d1_out_valid, d1_out_src, d1_out_data); end
  endtask

  task automatic test_out_of_range();
    d2_in_data = {8'h77, 8'h66, 8'h55};
    d2_in_valid = 3'b111;
    d2_out_ready = 1'b1;
    d2_sel = 2'd2;
    tick();
    checks++; if (d2_out_valid !== 1'b1 || d2_out_data !== 8'h77 || d2_out_src !== 2'd2) begin errors++; $display("FAIL oor_load: got v=%b d=%h s=%0d expected v=1 d=77 s=2", d2_out_valid, d2_out_data, d2_out_src); end
    d2_sel = 2'd3;
    #1;
    checks++; if (d2_in_ready !== 3'b000) begin errors++; $display("FAIL oor_ready: got %b expected 000", d2_in_ready); end
    tick();
    checks++; if (d2_out_valid !== 1'b0 || d2_out_data !== 8'h77) begin errors++; $display("FAIL oor_drain: got v=%b d=%h expected v=0 d=77", d2_out_valid, d2_out_data); end
    tick();
    checks++; if (d2_out_valid !== 1'b0) begin errors++; $display("FAIL oor_no_capture: got v=%b expected 0", d2_out_valid); end
    d2_sel = 2'd0;
    tick();
    checks++; if (d2_out_valid !== 1'b1 || d2_out_data !== 8'h55 || d2_out_src !== 2'd0) begin errors++; $display("FAIL oor_recover: got v=%b d=%h s=%0d expected v=1 d=55 s=0", d2_out_valid, d2_out_data, d2_out_src); end
    d2_out_ready = 1'b0;
    tick();
    checks++; if (d2_out_valid !== 1'b1 || d2_in_ready !== 3'b000) begin errors++; $display("FAIL stall_before_reset: got v=%b r=%b expected v=1 r=000", d2_out_valid, d2_in_ready); end
    rst_n = 1'b0;
    tick();
    checks++; if (d2_out_valid !== 1'b0 || d2_out_data !== 8'h00 || d2_out_src !== 2'd0) begin errors++; $display("FAIL midstall_reset: got v=%b d=%h s=%0d expected v=0 d=00 s=0", d2_out_valid, d2_out_data, d2_out_src); end
    d2_out_ready = 1'b1;
    #1;
    checks++; if (d2_in_ready !== 3'b000) begin errors++; $display("FAIL reset_forces_ready: got %b expected 000", d2_in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (d2_in_ready !== 3'b001) begin errors++; $display("FAIL post_reset_ready: got %b expected 001", d2_in_ready); end
    tick();
    checks++; if (d2_out_valid !== 1'b1 || d2_out_data !== 8'h55 || d2_out_src !== 2'd0) begin errors++; $display("FAIL post_reset_capture: got v=%b d=%h s=%0d expected v=1 d=55 s=0", d2_out_valid, d2_out_data, d2_out_src); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    d0_in_data = '0; d0_in_valid = '0; d0_sel = '0; d0_out_ready = 1'b0;
    d1_in_data = '0; d1_in_valid = '0; d1_sel = '0; d1_out_ready = 1'b0;
    d2_in_data = '0; d2_in_valid = '0; d2_sel = '0; d2_out_ready = 1'b0;
    test_reset();
    test_mode0_select();
    test_back_pressure();
    test_back_to_back();
    test_round_robin();
    test_rr_sparse();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
